mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, physical data-memory word address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter LOCK_MAX, default 8, maximum consecutive locked grants to one requester.
REQ-004 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-006 SHALL have ports reqN  in  1  access request (N=0 CPU data port, N=1 DMA/loader).
REQ-007 SHALL have ports lockN  in  1  keep grant after this access.
REQ-008 SHALL have ports weN  in  4  byte write enables (0000 = read).
REQ-009 SHALL have ports addrN  in  ADDR_W  and  wdataN  in  DATA_W  access address and write data.
REQ-010 SHALL have ports ackN  out  1  one-cycle completion pulse, and  rdataN  out  DATA_W  read data, valid with ackN.
REQ-011 SHALL have ports mem_en  out  1, mem_we  out  4, mem_addr  out  ADDR_W, mem_wdata  out  DATA_W; these drive the shared memory.
REQ-012 SHALL have port mem_rdata  in  DATA_W; valid one cycle after mem_en.
REQ-013 SHALL have ports busy  out  1  (state != IDLE) and lock_err  out  1  (sticky lock-limit flag).

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-015 IDLE: SHALL go to ACCESS when any reqN=1, latching the winner index, addr, we and wdata.
- On contention, the winner SHALL be the requester not served last.
- After reset, requester 0 SHALL win the first contention.
REQ-016 ACCESS: SHALL assert mem_en=1 for exactly one cycle with the latched we/addr/wdata, then go to RESP.
REQ-017 RESP: SHALL capture mem_rdata into rdataN, pulse ackN for one cycle, and update the last-served pointer.
REQ-018 Latency: request sampled at edge k SHALL give mem_en high during cycle k+1 and ackN high during cycle k+2.
REQ-019 Lock: if lockN=1 and reqN=1 in RESP, the FSM SHALL go directly to ACCESS for the same requester, bypassing arbitration; otherwise it SHALL go to IDLE.
REQ-020 A requester SHALL hold reqN and its operands stable until ackN.
- The arbiter SHALL ignore operand changes after latching.
REQ-021 Outside ACCESS, mem_en SHALL be 0 and mem_we SHALL be 0000.
- ack0 and ack1 SHALL never be high in the same cycle.
REQ-022 rdataN SHALL hold its last captured value between acks.
- A write access SHALL still capture mem_rdata.
REQ-023 Deassertion of reqN during ACCESS or RESP SHALL NOT abort the in-flight access.

Reset
REQ-024 When rst=1, the arbiter SHALL clear the following at the next edge: state=IDLE, last-served=1, lock counter=0, lock_err=0, ackN=0, rdataN=0, mem_en=0, mem_we=0.
REQ-025 Reset during ACCESS or RESP SHALL discard the access with no ack.
- The memory write cycle already issued SHALL stand.

Configuration
REQ-026 With macro MEM_ARB_LOCK_LIMIT_EN defined, the arbiter SHALL count consecutive locked grants.
- When the count reaches LOCK_MAX, RESP SHALL go to IDLE regardless of lockN.
- The other requester SHALL then win if requesting, and lock_err SHALL set, sticky until rst.
REQ-027 With MEM_ARB_LOCK_LIMIT_EN undefined, lock SHALL be unlimited, the counter SHALL be absent, and lock_err SHALL be tied to 0.

Structure
REQ-028 The FSM state enum, requester index constants and byte-enable width SHALL be in shared package mem_arb_pkg.
REQ-029 Winner selection SHALL be a sub-module rr_pick2: inputs req[1:0] and last; output grant index.

Verification
REQ-030 Single read: req0=1, addr0=0x010, we0=0000, memory word 0xDEADBEEF -> mem_en during k+1, ack0 at k+2, rdata0=0xDEADBEEF.
REQ-031 Contention: req0=req1=1 after reset, twice each -> grant order 0,1,0,1 and four acks total.
REQ-032 Lock RMW: req1 with lock1=1, read then write 0x00000055 with we1=1111 -> two back-to-back accesses with no IDLE cycle; req0 waits until after the second ack1.
REQ-033 Lock limit (macro on, LOCK_MAX=8): lock0 held high with req1 pending -> ack0 exactly 8 times, then ack1; lock_err=1.
REQ-034 Reset mid-access: rst=1 in ACCESS -> no ackN; outputs return to reset values next cycle; busy=0.
REQ-035 Byte write: we0=0010, wdata0=0x0000AB00 -> mem_we=0010 for exactly one cycle; read-back byte 1 = 0xAB.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package mem_arb_pkg;

    localparam int unsigned BE_W = 4;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arbState_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner selection: the requester not served last wins a tie.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = REQ_CPU;
        if (req == 2'b11) begin
            grant = ~last;
        end else if (req[1]) begin
            grant = REQ_DMA;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates CPU (0) and DMA/loader (1) onto one synchronous data memory, with lock chaining.
// Optional MEM_ARB_LOCK_LIMIT_EN caps consecutive locked grants at LOCK_MAX and flags lock_err.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              lock0,
    input  logic [BE_W-1:0]   we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              lock1,
    input  logic [BE_W-1:0]   we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic [BE_W-1:0]   mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              lock_err
);

    arbState_t         state;
    logic              owner;
    logic              lastServed;
    logic [DATA_W-1:0] rdHold0;
    logic [DATA_W-1:0] rdHold1;

    logic              grantPick;
    logic              issueIdx;
    logic              ownerReq;
    logic              ownerLock;
    logic [BE_W-1:0]   issueWe;
    logic [ADDR_W-1:0] issueAddr;
    logic [DATA_W-1:0] issueWdata;

    rr_pick2 uPick (
        .req   ({req1, req0}),
        .last  (lastServed),
        .grant (grantPick)
    );

    // A locked re-grant reuses the current owner; otherwise the arbitration winner is issued.
    assign issueIdx   = (state == RESP) ? owner : grantPick;
    assign issueWe    = (issueIdx == REQ_DMA) ? we1    : we0;
    assign issueAddr  = (issueIdx == REQ_DMA) ? addr1  : addr0;
    assign issueWdata = (issueIdx == REQ_DMA) ? wdata1 : wdata0;
    assign ownerReq   = (owner == REQ_DMA) ? req1  : req0;
    assign ownerLock  = (owner == REQ_DMA) ? lock1 : lock0;

    // Memory data arrives during the ack cycle, so it is forwarded then and held afterwards.
    assign rdata0 = ack0 ? mem_rdata : rdHold0;
    assign rdata1 = ack1 ? mem_rdata : rdHold1;
    assign busy   = (state != IDLE);

`ifdef MEM_ARB_LOCK_LIMIT_EN
    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
    logic [CNT_W-1:0] lockCnt;
    logic             lockErr;
    assign lock_err = lockErr;
`else
    assign lock_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= REQ_CPU;
            lastServed <= REQ_DMA;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdHold0    <= '0;
            rdHold1    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
`ifdef MEM_ARB_LOCK_LIMIT_EN
            lockCnt    <= '0;
            lockErr    <= 1'b0;
`endif
        end else begin
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= '0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state     <= ACCESS;
                        owner     <= issueIdx;
                        mem_en    <= 1'b1;
                        mem_we    <= issueWe;
                        mem_addr  <= issueAddr;
                        mem_wdata <= issueWdata;
`ifdef MEM_ARB_LOCK_LIMIT_EN
                        lockCnt   <= CNT_W'(1);
`endif
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    if (owner == REQ_DMA) begin
                        ack1 <= 1'b1;
                    end else begin
                        ack0 <= 1'b1;
                    end
                end
                RESP: begin
                    lastServed <= owner;
                    if (owner == REQ_DMA) begin
                        rdHold1 <= mem_rdata;
                    end else begin
                        rdHold0 <= mem_rdata;
                    end
                    state <= IDLE;
                    if (ownerLock && ownerReq) begin
`ifdef MEM_ARB_LOCK_LIMIT_EN
                        if (lockCnt >= CNT_W'(LOCK_MAX)) begin
                            lockErr <= 1'b1;
                        end else begin
                            state     <= ACCESS;
                            mem_en    <= 1'b1;
                            mem_we    <= issueWe;
                            mem_addr  <= issueAddr;
                            mem_wdata <= issueWdata;
                            lockCnt   <= lockCnt + CNT_W'(1);
                        end
`else
                        state     <= ACCESS;
                        mem_en    <= 1'b1;
                        mem_we    <= issueWe;
                        mem_addr  <= issueAddr;
                        mem_wdata <= issueWdata;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter with a small synchronous memory model.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, lock0, req1, lock1;
    logic [3:0]  we0, we1;
    logic [10:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        busy, lock_err;

    logic [31:0] mem [0:63];
    logic        bdEn = 1'b0;
    logic [5:0]  bdAddr = '0;
    logic [31:0] bdData = '0;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .lock0(lock0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .lock1(lock1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .lock_err(lock_err)
    );

    // Synchronous memory: read-before-write, data valid the cycle after mem_en.
    always @(posedge clk) begin
        if (bdEn) mem[bdAddr] <= bdData;
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= mem[mem_addr[5:0]];
        end
    end

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        bdEn = 1'b1; bdAddr = a; bdData = d;
        @(negedge clk);
        bdEn = 1'b0;
    endtask

    task automatic idleInputs();
        req0 = 0; lock0 = 0; we0 = '0; addr0 = '0; wdata0 = '0;
        req1 = 0; lock1 = 0; we1 = '0; addr1 = '0; wdata1 = '0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitAck(input int budget, output logic got0, output logic got1);
        got0 = 0; got1 = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                got0 = ack0; got1 = ack1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        idleInputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ack0 !== 1'b0 || ack1 !== 1'b0) $display("FAIL reset_acks got %b%b want 00", ack0, ack1); else passes++;
        checks++; if (mem_en !== 1'b0 || mem_we !== 4'b0000) $display("FAIL reset_mem got en=%b we=%b want 0/0000", mem_en, mem_we); else passes++;
        checks++; if (busy !== 1'b0 || lock_err !== 1'b0) $display("FAIL reset_flags got busy=%b err=%b want 0/0", busy, lock_err); else passes++;
        checks++; if (rdata0 !== 32'h0 || rdata1 !== 32'h0) $display("FAIL reset_rdata got %h %h want 0 0", rdata0, rdata1); else passes++;
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        logic g0, g1;
        preload(6'h10, 32'hDEADBEEF);
        req0 = 1; addr0 = 11'h010; we0 = 4'b0000;
        @(negedge clk);
        checks++; if (mem_en !== 1'b1 || mem_addr !== 11'h010 || mem_we !== 4'b0000)
            $display("FAIL read_issue got en=%b addr=%h we=%b want 1/010/0000", mem_en, mem_addr, mem_we); else passes++;
        checks++; if (ack0 !== 1'b0 || busy !== 1'b1) $display("FAIL read_early got ack0=%b busy=%b want 0/1", ack0, busy); else passes++;
        @(negedge clk);
        checks++; if (ack0 !== 1'b1 || ack1 !== 1'b0 || mem_en !== 1'b0)
            $display("FAIL read_ack got ack0=%b ack1=%b en=%b want 1/0/0", ack0, ack1, mem_en); else passes++;
        checks++; if (rdata0 !== 32'hDEADBEEF) $display("FAIL read_data got %h want deadbeef", rdata0); else passes++;
        req0 = 0;
        @(negedge clk);
        checks++; if (ack0 !== 1'b0 || rdata0 !== 32'hDEADBEEF || busy !== 1'b0)
            $display("FAIL read_hold got ack0=%b rdata0=%h busy=%b want 0/deadbeef/0", ack0, rdata0, busy); else passes++;
        g0 = 0; g1 = 0;
    endtask

    task automatic test_contention();
        int order[$];
        int rem0, rem1;
        logic both;
        logic [31:0] rd1;
        doReset();
        preload(6'h20, 32'hA0A0A0A0);
        preload(6'h21, 32'hA1A1A1A1);
        rem0 = 2; rem1 = 2; both = 0; rd1 = '0;
        req0 = 1; addr0 = 11'h020; req1 = 1; addr1 = 11'h021;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            @(negedge clk);
            if (ack0 && ack1) both = 1;
            if (ack0) begin order.push_back(0); rem0--; if (rem0 == 0) req0 = 0; end
            if (ack1) begin order.push_back(1); rd1 = rdata1; rem1--; if (rem1 == 0) req1 = 0; end
        end
        req0 = 0; req1 = 0;
        checks++; if (order.size() != 4) $display("FAIL cont_count got %0d want 4", order.size()); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ((order.size() > i ? order[i] : -1) != i % 2)
                $display("FAIL cont_order%0d got %0d want %0d", i, (order.size() > i ? order[i] : -1), i % 2);
            else passes++;
        end
        checks++; if (both !== 1'b0) $display("FAIL cont_both got %b want 0", both); else passes++;
        checks++; if (rd1 !== 32'hA1A1A1A1) $display("FAIL cont_rdata1 got %h want a1a1a1a1", rd1); else passes++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lock_rmw();
        logic g0, g1;
        doReset();
        preload(6'h30, 32'h11223344);
        req1 = 1; lock1 = 1; addr1 = 11'h030; we1 = 4'b0000;
        @(negedge clk);
        req0 = 1; addr0 = 11'h031;
        @(negedge clk);
        checks++; if (ack1 !== 1'b1 || rdata1 !== 32'h11223344) $display("FAIL rmw_read got ack1=%b rdata1=%h want 1/11223344", ack1, rdata1); else passes++;
        we1 = 4'b1111; wdata1 = 32'h00000055;
        @(negedge clk);
        checks++; if (mem_en !== 1'b1 || mem_we !== 4'b1111 || mem_wdata !== 32'h55 || busy !== 1'b1)
            $display("FAIL rmw_write_issue got en=%b we=%b wd=%h busy=%b want 1/1111/55/1", mem_en, mem_we, mem_wdata, busy); else passes++;
        lock1 = 0;
        @(negedge clk);
        checks++; if (ack1 !== 1'b1 || ack0 !== 1'b0) $display("FAIL rmw_ack2 got ack1=%b ack0=%b want 1/0", ack1, ack0); else passes++;
        checks++; if (rdata1 !== 32'h11223344) $display("FAIL rmw_wr_capture got %h want 11223344", rdata1); else passes++;
        req1 = 0; we1 = '0;
        @(negedge clk);
        checks++; if (mem[6'h30] !== 32'h00000055) $display("FAIL rmw_mem got %h want 00000055", mem[6'h30]); else passes++;
        waitAck(10, g0, g1);
        checks++; if (g0 !== 1'b1 || g1 !== 1'b0) $display("FAIL rmw_cpu_after got ack0=%b ack1=%b want 1/0", g0, g1); else passes++;
        req0 = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lock_limit();
        int n0;
        logic seen1, timeout;
`ifdef MEM_ARB_LOCK_LIMIT_EN
        localparam int EXP_N0 = 8;
        localparam logic EXP_ERR = 1'b1;
`else
        localparam int EXP_N0 = 10;
        localparam logic EXP_ERR = 1'b0;
`endif
        doReset();
        n0 = 0; seen1 = 0; timeout = 1;
        req0 = 1; lock0 = 1; addr0 = 11'h010; we0 = '0;
        @(negedge clk);
        req1 = 1; addr1 = 11'h020; we1 = '0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (ack0) begin
                n0++;
                if (n0 == 10) lock0 = 0;
            end
            if (ack1) begin
                seen1 = 1; timeout = 0;
                req0 = 0; req1 = 0; lock0 = 0;
                break;
            end
        end
        req0 = 0; req1 = 0; lock0 = 0;
        checks++; if (timeout) $display("FAIL lock_timeout got no ack1 want ack1"); else passes++;
        checks++; if (n0 != EXP_N0) $display("FAIL lock_count got %0d want %0d", n0, EXP_N0); else passes++;
        checks++; if (lock_err !== EXP_ERR) $display("FAIL lock_err got %b want %b", lock_err, EXP_ERR); else passes++;
        repeat (2) @(negedge clk);
        seen1 = 0;
    endtask

    task automatic test_reset_mid();
        int acks;
        preload(6'h10, 32'hDEADBEEF);
        req0 = 1; addr0 = 11'h010; we0 = '0;
        @(negedge clk);
        checks++; if (mem_en !== 1'b1) $display("FAIL mid_issue got en=%b want 1", mem_en); else passes++;
        rst = 1;
        @(negedge clk);
        checks++; if (ack0 !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0 || mem_we !== 4'b0000)
            $display("FAIL mid_reset got ack0=%b busy=%b en=%b we=%b want 0/0/0/0000", ack0, busy, mem_en, mem_we); else passes++;
        checks++; if (rdata0 !== 32'h0 || lock_err !== 1'b0) $display("FAIL mid_rdata got %h err=%b want 0/0", rdata0, lock_err); else passes++;
        rst = 0; req0 = 0;
        acks = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (ack0 || ack1) acks++;
        end
        checks++; if (acks != 0) $display("FAIL mid_noack got %0d want 0", acks); else passes++;
    endtask

    task automatic test_byte_write();
        int weHits;
        logic done;
        logic g0, g1;
        preload(6'h40, 32'h11111111);
        weHits = 0; done = 0;
        req0 = 1; addr0 = 11'h040; we0 = 4'b0010; wdata0 = 32'h0000AB00;
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            if (mem_we == 4'b0010) weHits++;
            if (ack0) done = 1;
        end
        req0 = 0; we0 = '0;
        checks++; if (weHits != 1) $display("FAIL bw_we_cycles got %0d want 1", weHits); else passes++;
        @(negedge clk);
        req0 = 1; addr0 = 11'h040;
        waitAck(8, g0, g1);
        req0 = 0;
        checks++; if (g0 !== 1'b1 || rdata0[15:8] !== 8'hAB) $display("FAIL bw_byte1 got ack=%b byte=%h want 1/ab", g0, rdata0[15:8]); else passes++;
        checks++; if (rdata0 !== 32'h1111AB11) $display("FAIL bw_word got %h want 1111ab11", rdata0); else passes++;
        @(negedge clk);
    endtask

    initial begin
        idleInputs();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_read();
        test_contention();
        test_lock_rmw();
        test_lock_limit();
        test_reset_mid();
        test_byte_write();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
